// File: rtl/aes_key_mem_if.sv
// aes_key_mem_if: key-memory bus between the AES key expansion and its consumer / shared S-box.
// With AES_KEY_MEM_ZEROIZE_EN defined the bus also carries the zeroize request.
interface aes_key_mem_if;
    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
`ifdef AES_KEY_MEM_ZEROIZE_EN
    logic         zeroize;

    modport master (output key, keylen, init, round, new_sboxw, zeroize,
                    input round_key, ready, sboxw);
    modport slave (input key, keylen, init, round, new_sboxw, zeroize,
                   output round_key, ready, sboxw);
`else
    modport master (output key, keylen, init, round, new_sboxw,
                    input round_key, ready, sboxw);
    modport slave (input key, keylen, init, round, new_sboxw,
                   output round_key, ready, sboxw);
`endif
endinterface

// File: rtl/aes_key_mem.sv
// aes_key_mem: AES-128/256 key expansion into a 15 x 128-bit round-key store with a combinational read port.
// Optional AES_KEY_MEM_ZEROIZE_EN adds a zeroize input that wipes key material and aborts generation.
module aes_key_mem #(
    parameter int NUM_ENTRIES = 15
) (
    input logic         clk,
    input logic         reset_n,
    aes_key_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, GENERATE, DONE} state_t;

    state_t       state, state_next;
    logic [127:0] mem [NUM_ENTRIES];
    logic [255:0] key_reg;
    logic         keylen_reg;
    logic [127:0] prev0, prev1;
    logic [3:0]   round_ctr;
    logic [7:0]   rcon;
    logic [7:0]   rcon_next;
    logic [3:0]   last_round;
    logic         zeroize;
    logic         odd256;
    logic [31:0]  w3, t, k0, k1, k2, k3;
    logic [127:0] base, new_key;

`ifdef AES_KEY_MEM_ZEROIZE_EN
    assign zeroize = bus.zeroize;
`else
    assign zeroize = 1'b0;
`endif

    assign last_round = keylen_reg ? 4'd14 : 4'd10;
    assign rcon_next = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
    assign odd256 = keylen_reg & round_ctr[0];
    assign w3 = prev1[31:0];
    assign bus.sboxw = odd256 ? w3 : {w3[23:0], w3[31:24]};
    assign bus.round_key = (32'(bus.round) < NUM_ENTRIES) ? mem[bus.round] : '0;

    // state register; zeroize forces the FSM back to idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= zeroize ? IDLE : state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = bus.init ? INIT : IDLE;
            INIT:     state_next = GENERATE;
            GENERATE: state_next = (round_ctr == last_round) ? DONE : GENERATE;
            default:  state_next = IDLE;
        endcase
    end

    // outputs and the next round key; AES-256 chains off entry r-2, AES-128 off entry r-1
    always_comb begin
        bus.ready = state == IDLE;
        t = bus.new_sboxw ^ (odd256 ? 32'h0 : {rcon, 24'h0});
        base = keylen_reg ? prev0 : prev1;
        k0 = base[127:96] ^ t;
        k1 = base[95:64] ^ k0;
        k2 = base[63:32] ^ k1;
        k3 = base[31:0] ^ k2;
        new_key = (keylen_reg && round_ctr == 4'd1) ? key_reg[127:0] : {k0, k1, k2, k3};
    end

    // key latch, round-key memory writes and chaining registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                mem[i] <= '0;
            key_reg <= '0;
            keylen_reg <= 1'b0;
            prev0 <= '0;
            prev1 <= '0;
            round_ctr <= '0;
            rcon <= 8'h01;
        end else if (zeroize) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                mem[i] <= '0;
            key_reg <= '0;
            prev0 <= '0;
            prev1 <= '0;
        end else begin
            if (state == IDLE && bus.init) begin
                key_reg <= bus.key;
                keylen_reg <= bus.keylen;
                rcon <= 8'h01;
                round_ctr <= '0;
            end
            if (state == INIT) begin
                mem[0] <= key_reg[255:128];
                prev1 <= key_reg[255:128];
                round_ctr <= 4'd1;
            end
            if (state == GENERATE) begin
                mem[round_ctr] <= new_key;
                prev0 <= prev1;
                prev1 <= new_key;
                round_ctr <= round_ctr + 4'd1;
                if (!odd256)
                    rcon <= rcon_next;
            end
        end
    end
endmodule

// File: doc/aes_key_mem.md
Name: aes_key_mem

Overview:
Key expansion and round-key store feeding the decipher round's round_key input. On an init pulse it expands a 128- or 256-bit cipher key, one round key per cycle, into a 15-entry x 128-bit memory. The decipher sequencer then reads any round key by index through a combinational read port. SubWord is computed by an external shared S-box, connected through the sboxw/new_sboxw ports.

Parameters:
NUM_ENTRIES, 15, round-key slots (indices 0..14); fixed by AES-256, not meant to be overridden.

Ports:
clk  input  1  system clock
reset_n  input  1  reset
key  input  256  cipher key; AES-128 uses key[255:128] only
keylen  input  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds)
init  input  1  single-cycle start pulse
round  input  4  round-key read index
round_key  output  128  memory[round]; combinational read
ready  output  1  high = idle and keys valid/stable
sboxw  output  32  word sent to the external S-box
new_sboxw  input  32  S-box result, combinational from sboxw, same cycle

Interface rule (already decided): one clock; reset is asynchronous and active-low (reset_n).

Behaviour:
- Reset values:
  - ready = 1.
  - All 15 memory entries = 0, so round_key = 0.
  - Internal key, prev-key registers and round counter = 0; rcon = 8'h01.
  - sboxw = 0; FSM = IDLE.
- FSM states: IDLE, INIT, GENERATE, DONE.
- IDLE:
  - init=1 latches key and keylen, clears ready, loads rcon = 8'h01, round_ctr = 0, goes to INIT.
  - init while not in IDLE is ignored.
- INIT (1 cycle): write mem[0] = key[255:128]; round_ctr = 1; go to GENERATE.
- GENERATE: one entry written per cycle at mem[round_ctr], then round_ctr increments.
  - Leave when round_ctr reaches 10 (AES-128) or 14 (AES-256) and that entry has been written; go to DONE.
- DONE (1 cycle): ready = 1; back to IDLE.
- Latency, with init sampled at edge N:
  - AES-128: ready high after edge N+12.
  - AES-256: ready high after edge N+16.
- AES-128 step, with previous key words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - k0 = w0 ^ t; k1 = w1 ^ k0; k2 = w2 ^ k1; k3 = w3 ^ k2
  - rcon updated after every step.
- AES-256 steps:
  - mem[1] = key[127:0], written with no S-box use.
  - For r >= 2, words chain off entry r-2 (w0..w3) and entry r-1 (w3 only).
  - r even: t = SubWord(RotWord(prev1.w3)) ^ {rcon, 24'h0}; rcon updated afterwards.
  - r odd: t = SubWord(prev1.w3); no rotation, no rcon.
  - Chaining then proceeds as in AES-128.
- rcon update: next = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}}).
- sboxw is driven with RotWord(w3) or w3 combinationally; value is don't-care outside GENERATE.
- Read port:
  - round_key reflects the memory write on the following cycle.
  - round = 15 returns 128'h0.
  - AES-128 entries 11..14 keep their previous contents (not cleared by init).
- Reads while ready=0 return partially updated contents; the consumer must wait for ready.
- Reset asserted mid-generation aborts immediately to reset values, including the memory clear.
- Back-to-back: init on the same cycle ready rises is accepted, since the FSM is in IDLE by then.

Optional Feature:
Macro AES_KEY_MEM_ZEROIZE_EN.
- Defined:
  - Extra input port zeroize (1 bit).
  - zeroize=1 on any cycle clears all 15 entries, the latched key and the prev-key registers at that edge.
  - It aborts any generation and forces FSM = IDLE, ready = 1.
  - zeroize has priority over a simultaneous init (the init is dropped).
- Not defined: port absent; memory is cleared only by reset_n.

Test Plan:
1. AES-128: key[255:128] = 2b7e151628aed2a6abf7158809cf4f3c, keylen=0, init pulse.
   -> ready low for 12 cycles; round 0 = the key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
2. AES-256: key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, keylen=1, init.
   -> ready after 16 cycles; round 1 = 1f352c073b6108d72d9810a30914dff4; round 14 = fe4890d1e6188d0b046df344706c631e.
3. Second init pulse 3 cycles after the first, with a different key.
   -> ignored; final keys match the first key; ready timing unchanged.
4. reset_n low at cycle 5 of AES-256 generation.
   -> ready = 1 and round_key = 0 for every index immediately; a fresh init then yields the correct keys from test 2.
5. After test 1, read round = 15.
   -> 128'h0. Then run AES-256 and rerun AES-128: entries 11..14 still hold the AES-256 values.
6. (AES_KEY_MEM_ZEROIZE_EN) zeroize pulse mid-generation, and again with init on the same cycle.
   -> all entries 0, ready = 1 next cycle, init dropped.
